// File: rtl/fpu_pkg.sv
// Shared FPU add/sub datapath definitions: default widths, GRS width and the
// aligned-operand bundle handed from the alignment stage to the mantissa adder.
package fpu_pkg;

    localparam int EW_DEF = 8;
    localparam int MW_DEF = 24;
    localparam int GRS_W  = 3;

    typedef struct packed {
        logic [EW_DEF-1:0]        exp_big;
        logic [MW_DEF-1:0]        man_big;
        logic [MW_DEF+GRS_W-1:0]  man_small_al;
        logic [EW_DEF-1:0]        diff;
        logic                     swap;
        logic                     eq;
    } align_bundle_t;

endpackage

// File: rtl/sticky_rshift.sv
// Combinational barrel right shift that folds every shifted-out bit into the
// result LSB (sticky); shifts of W or more collapse to the OR of the input.
module sticky_rshift #(
    parameter int W  = 27,
    parameter int SW = 8
) (
    input  logic [W-1:0]  data_i,
    input  logic [SW-1:0] amt_i,
    output logic [W-1:0]  data_o
);

    logic [W-1:0] shifted_s;
    logic [W-1:0] lost_mask_s;
    logic         lost_s;

    // Shift, collect the lost bits, and apply the saturation rule.
    always_comb begin
        shifted_s   = data_i >> amt_i;
        lost_mask_s = ~({W{1'b1}} << amt_i);
        lost_s      = |(data_i & lost_mask_s);
        if (32'(amt_i) >= W) begin
            data_o = {{(W-1){1'b0}}, |data_i};
        end else begin
            data_o = {shifted_s[W-1:1], shifted_s[0] | lost_s};
        end
    end

endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage exponent compare / mantissa align pipeline feeding the FPU
// mantissa adder, with a valid/ready handshake at one pair per cycle.
module exp_align_pipe
    import fpu_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int MW = MW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW-1:0]       exp_a,
    input  logic [EW-1:0]       exp_b,
    input  logic [MW-1:0]       man_a,
    input  logic [MW-1:0]       man_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EW-1:0]       exp_big,
    output logic [MW-1:0]       man_big,
    output logic [MW+GRS_W-1:0] man_small_al,
    output logic [EW-1:0]       diff,
    output logic                swap,
    output logic                eq
);

    localparam int AW = MW + GRS_W;

    logic [EW:0]    sub_s;
    logic [EW-1:0]  d_s;
    logic [EW-1:0]  diff_s;
    logic           borrow_s;
    logic           eq_s;
    logic           swap_s;
    logic [EW-1:0]  exp_big_s;
    logic [MW-1:0]  man_big_s;
    logic [MW-1:0]  man_small_s;
    logic [AW-1:0]  aligned_s;

    logic           adv2_s;
    logic           in_ready_s;
    logic           load1_s;
    logic           load2_s;

    logic           v1_d, v1_q;
    logic [EW-1:0]  s1_exp_big_d, s1_exp_big_q;
    logic [MW-1:0]  s1_man_big_d, s1_man_big_q;
    logic [MW-1:0]  s1_man_small_d, s1_man_small_q;
    logic [EW-1:0]  s1_diff_d, s1_diff_q;
    logic           s1_swap_d, s1_swap_q;
    logic           s1_eq_d, s1_eq_q;

    logic           v2_d, v2_q;
    logic [EW-1:0]  s2_exp_big_d, s2_exp_big_q;
    logic [MW-1:0]  s2_man_big_d, s2_man_big_q;
    logic [AW-1:0]  s2_man_small_al_d, s2_man_small_al_q;
    logic [EW-1:0]  s2_diff_d, s2_diff_q;
    logic           s2_swap_d, s2_swap_q;
    logic           s2_eq_d, s2_eq_q;

    // Stage 1 compare: ties on exponent go to the larger mantissa so that the
    // downstream magnitude subtraction never goes negative.
    always_comb begin
        sub_s       = {1'b0, exp_a} - {1'b0, exp_b};
        borrow_s    = sub_s[EW];
        d_s         = sub_s[EW-1:0];
        diff_s      = borrow_s ? ({EW{1'b0}} - d_s) : d_s;
        eq_s        = (exp_a == exp_b);
        swap_s      = borrow_s | (eq_s & (man_b > man_a));
        exp_big_s   = swap_s ? exp_b : exp_a;
        man_big_s   = swap_s ? man_b : man_a;
        man_small_s = swap_s ? man_a : man_b;
    end

    sticky_rshift #(
        .W  (AW),
        .SW (EW)
    ) u_align (
        .data_i ({s1_man_small_q, {GRS_W{1'b0}}}),
        .amt_i  (s1_diff_q),
        .data_o (aligned_s)
    );

    // Handshake: stage 2 drains when empty or accepted; no skid buffer.
    always_comb begin
        adv2_s     = ~v2_q | out_ready;
        in_ready_s = ~v1_q | adv2_s;
        load1_s    = in_valid & in_ready_s;
        load2_s    = v1_q & adv2_s;
    end

    // Next-state for both stages; data registers only move on advance.
    always_comb begin
        v1_d              = in_ready_s ? in_valid : v1_q;
        s1_exp_big_d      = load1_s ? exp_big_s   : s1_exp_big_q;
        s1_man_big_d      = load1_s ? man_big_s   : s1_man_big_q;
        s1_man_small_d    = load1_s ? man_small_s : s1_man_small_q;
        s1_diff_d         = load1_s ? diff_s      : s1_diff_q;
        s1_swap_d         = load1_s ? swap_s      : s1_swap_q;
        s1_eq_d           = load1_s ? eq_s        : s1_eq_q;

        v2_d              = adv2_s ? v1_q : v2_q;
        s2_exp_big_d      = load2_s ? s1_exp_big_q : s2_exp_big_q;
        s2_man_big_d      = load2_s ? s1_man_big_q : s2_man_big_q;
        s2_man_small_al_d = load2_s ? aligned_s    : s2_man_small_al_q;
        s2_diff_d         = load2_s ? s1_diff_q    : s2_diff_q;
        s2_swap_d         = load2_s ? s1_swap_q    : s2_swap_q;
        s2_eq_d           = load2_s ? s1_eq_q      : s2_eq_q;
    end

    // Pipeline registers; reset drops any in-flight pair immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q              <= 1'b0;
            s1_exp_big_q      <= {EW{1'b0}};
            s1_man_big_q      <= {MW{1'b0}};
            s1_man_small_q    <= {MW{1'b0}};
            s1_diff_q         <= {EW{1'b0}};
            s1_swap_q         <= 1'b0;
            s1_eq_q           <= 1'b0;
            v2_q              <= 1'b0;
            s2_exp_big_q      <= {EW{1'b0}};
            s2_man_big_q      <= {MW{1'b0}};
            s2_man_small_al_q <= {AW{1'b0}};
            s2_diff_q         <= {EW{1'b0}};
            s2_swap_q         <= 1'b0;
            s2_eq_q           <= 1'b0;
        end else begin
            v1_q              <= v1_d;
            s1_exp_big_q      <= s1_exp_big_d;
            s1_man_big_q      <= s1_man_big_d;
            s1_man_small_q    <= s1_man_small_d;
            s1_diff_q         <= s1_diff_d;
            s1_swap_q         <= s1_swap_d;
            s1_eq_q           <= s1_eq_d;
            v2_q              <= v2_d;
            s2_exp_big_q      <= s2_exp_big_d;
            s2_man_big_q      <= s2_man_big_d;
            s2_man_small_al_q <= s2_man_small_al_d;
            s2_diff_q         <= s2_diff_d;
            s2_swap_q         <= s2_swap_d;
            s2_eq_q           <= s2_eq_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = v2_q;
    assign exp_big      = s2_exp_big_q;
    assign man_big      = s2_man_big_q;
    assign man_small_al = s2_man_small_al_q;
    assign diff         = s2_diff_q;
    assign swap         = s2_swap_q;
    assign eq           = s2_eq_q;

endmodule
